// File: rtl/memory_stage_pkg.sv
// Shared types and helpers for the memory pipeline stage.
package memory_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Width of a timer that must hold values up to TIMEOUT.
  function automatic int timer_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/mw_register.sv
// M/W pipeline register. i_en loads the control/ALU fields, while i_rd_en
// loads the read-data field on its own. i_clr clears every field.
module mw_register #(
  parameter int WIDTH = 32,
  parameter int REGW  = 4
) (
  input  logic             clk,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_rd_en,
  input  logic [WIDTH-1:0] i_read_data,
  input  logic [WIDTH-1:0] i_alu_out,
  input  logic [REGW-1:0]  i_wa3,
  input  logic             i_reg_write,
  input  logic             i_mem_to_reg,
  output logic [WIDTH-1:0] o_read_data,
  output logic [WIDTH-1:0] o_alu_out,
  output logic [REGW-1:0]  o_wa3,
  output logic             o_reg_write,
  output logic             o_mem_to_reg
);

  // W register fields with synchronous clear
  always_ff @(posedge clk) begin
    if (i_clr) begin
      o_read_data  <= {WIDTH{1'b0}};
      o_alu_out    <= {WIDTH{1'b0}};
      o_wa3        <= {REGW{1'b0}};
      o_reg_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
    end else begin
      if (i_en) begin
        o_alu_out    <= i_alu_out;
        o_wa3        <= i_wa3;
        o_reg_write  <= i_reg_write;
        o_mem_to_reg <= i_mem_to_reg;
      end
      if (i_rd_en) begin
        o_read_data <= i_read_data;
      end
    end
  end

endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage. It issues loads and stores over a valid/ack
// handshake, stalls upstream while an access is in flight, and feeds the
// M/W register.
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int REGW    = 4,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ValidM,
  input  logic             MemReadM,
  input  logic             MemWriteM,
  input  logic             RegWriteM,
  input  logic             MemtoRegM,
  input  logic [REGW-1:0]  WA3M,
  input  logic [WIDTH-1:0] ALUResultM,
  input  logic [WIDTH-1:0] WriteDataM,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic             StallM,
  output logic             MemErr,
  output logic [WIDTH-1:0] ReadDataW,
  output logic [WIDTH-1:0] ALUOutW,
  output logic [REGW-1:0]  WA3W,
  output logic             RegWriteW,
  output logic             MemtoRegW
);

  localparam int TW = timer_width(TIMEOUT);

  mem_state_t       r_state, w_state_nx;
  logic [TW-1:0]    r_timer, w_timer_nx;
  logic             r_aborted, w_aborted_nx;
  logic             r_req, w_req_nx;
  logic             r_we, w_we_nx;
  logic [WIDTH-1:0] r_addr, w_addr_nx;
  logic [WIDTH-1:0] r_wdata, w_wdata_nx;
  logic [WIDTH-1:0] r_load_data, w_load_data_nx;
  logic             r_err, w_err_nx;
  logic             w_memop, w_stall, w_w_en, w_rd_en, w_reg_write;
  logic [WIDTH-1:0] w_rd_val;

  assign w_memop = ValidM & (MemReadM | MemWriteM);

  // State and handshake registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_timer     <= {TW{1'b0}};
      r_aborted   <= 1'b0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= {WIDTH{1'b0}};
      r_wdata     <= {WIDTH{1'b0}};
      r_load_data <= {WIDTH{1'b0}};
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_timer     <= w_timer_nx;
      r_aborted   <= w_aborted_nx;
      r_req       <= w_req_nx;
      r_we        <= w_we_nx;
      r_addr      <= w_addr_nx;
      r_wdata     <= w_wdata_nx;
      r_load_data <= w_load_data_nx;
      r_err       <= w_err_nx;
    end
  end

  // Next-state, stall and W-register load control
  always_comb begin
    w_state_nx     = r_state;
    w_timer_nx     = r_timer;
    w_aborted_nx   = r_aborted;
    w_req_nx       = r_req;
    w_we_nx        = r_we;
    w_addr_nx      = r_addr;
    w_wdata_nx     = r_wdata;
    w_load_data_nx = r_load_data;
    w_err_nx       = r_err;
    w_stall        = 1'b0;
    w_w_en         = 1'b0;
    w_rd_en        = 1'b0;
    w_rd_val       = r_load_data;
    w_reg_write    = RegWriteM & ValidM;
    case (r_state)
      IDLE: begin
        w_stall = w_memop;
        if (w_memop) begin
          w_addr_nx    = ALUResultM;
          w_wdata_nx   = WriteDataM;
          w_we_nx      = MemWriteM;
          w_req_nx     = 1'b1;
          w_timer_nx   = {TW{1'b0}};
          w_aborted_nx = 1'b0;
          w_state_nx   = WAIT;
        end else begin
          w_w_en = 1'b1;
        end
      end
      WAIT: begin
        w_stall = 1'b1;
        if (mem_ack) begin
          if (!r_we) begin
            w_load_data_nx = mem_rdata;
          end else begin
            w_load_data_nx = r_load_data;
          end
          w_req_nx   = 1'b0;
          w_state_nx = DONE;
        end else if (r_timer == TW'(TIMEOUT - 1)) begin
          w_req_nx     = 1'b0;
          w_err_nx     = 1'b1;
          w_aborted_nx = 1'b1;
          w_state_nx   = DONE;
        end else begin
          w_timer_nx = r_timer + TW'(1);
        end
      end
      DONE: begin
        // Stores keep the old read data unless the access was aborted
        w_w_en      = 1'b1;
        w_rd_en     = r_aborted | ~r_we;
        w_rd_val    = r_aborted ? {WIDTH{1'b0}} : r_load_data;
        w_reg_write = RegWriteM & ValidM & ~r_aborted;
        w_state_nx  = IDLE;
      end
      default: begin
        w_state_nx = IDLE;
      end
    endcase
  end

  assign StallM    = w_stall;
  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign MemErr    = r_err;

  mw_register #(
    .WIDTH (WIDTH),
    .REGW  (REGW)
  ) u_mw_register (
    .clk          (clk),
    .i_clr        (reset),
    .i_en         (w_w_en),
    .i_rd_en      (w_rd_en),
    .i_read_data  (w_rd_val),
    .i_alu_out    (ALUResultM),
    .i_wa3        (WA3M),
    .i_reg_write  (w_reg_write),
    .i_mem_to_reg (MemtoRegM),
    .o_read_data  (ReadDataW),
    .o_alu_out    (ALUOutW),
    .o_wa3        (WA3W),
    .o_reg_write  (RegWriteW),
    .o_mem_to_reg (MemtoRegW)
  );

endmodule
